// File: rtl/latch_stim_pkg.sv
// Shared types and helpers for the latch stimulus generator.
//   op_e    : command opcodes carried on the command bus
//   state_e : sequencer phases
//   phase_cnt_w() : width of the phase down-counter for given phase lengths
package latch_stim_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_RESET = 2'd2,
        OP_HOLD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_e;

    // Counter holds (length - 1) of the longest phase; never narrower than one bit.
    function automatic int unsigned phase_cnt_w(input int unsigned s,
                                                input int unsigned p,
                                                input int unsigned h);
        int unsigned m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/latch_stim_gen_if.sv
// Command bus between the bench command source and the stimulus generator.
//   cmd_valid : command offered (master -> slave)
//   cmd_ready : command accepted when valid && ready (slave -> master)
//   cmd_op    : opcode (master -> slave)
//   cmd_data  : D value for OP_WRITE (master -> slave)
interface latch_stim_gen_if;
    import latch_stim_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    op_e  cmd_op;
    logic cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/latch_stim_chk.sv
// Result checker for the latch stimulus generator.
// Samples the cell's Q/QN on entry to CHECK, compares them against the expected model and keeps
// a saturating count of failed checks. With LATCH_STIM_GLITCH_CHK_EN defined it also watches
// Q/QN during the opaque SETUP/HOLD phases and counts any change from the value captured at
// phase entry; a glitch fails the current command.
// Ports:
//   clk, rst           : bench clock, async active-high reset
//   state_q, state_d   : current / next sequencer phase
//   exp_q, exp_vld     : expected cell state and whether it is known
//   lat_q, lat_qn      : cell outputs
//   done_pass          : check result, qualified by state_q == CHECK
//   err_cnt            : saturating failed-check count
//   glitch_cnt         : saturating opaque-phase change count (0 when the macro is undefined)
module latch_stim_chk
    import latch_stim_pkg::*;
#(
    parameter int unsigned ERRW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  state_e          state_q,
    input  state_e          state_d,
    input  logic            exp_q,
    input  logic            exp_vld,
    input  logic            lat_q,
    input  logic            lat_qn,
    output logic            done_pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [ERRW-1:0] glitch_cnt
);

    localparam logic [ERRW-1:0] CntMax = {ERRW{1'b1}};

    logic            q_s, qn_s;
    logic            pass;
    logic [ERRW-1:0] err_cnt_q;

`ifdef LATCH_STIM_GLITCH_CHK_EN
    logic            q_cap, qn_cap;
    logic            glitch_seen_q;
    logic            glitch_now;
    logic            cap_en;
    logic [ERRW-1:0] glitch_cnt_q;

    assign cap_en = ((state_d == SETUP) && (state_q != SETUP)) ||
                    ((state_d == HOLD)  && (state_q != HOLD));

    // An X/Z compare evaluates false here, so unknowns never count as glitches; they are
    // caught by the pass logic instead.
    always_comb begin
        glitch_now = 1'b0;
        if ((state_q == SETUP) || (state_q == HOLD)) begin
            if ((lat_q != q_cap) || (lat_qn != qn_cap)) glitch_now = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_cap         <= 1'b0;
            qn_cap        <= 1'b0;
            glitch_seen_q <= 1'b0;
            glitch_cnt_q  <= '0;
        end else begin
            if (cap_en) begin
                q_cap  <= lat_q;
                qn_cap <= lat_qn;
            end
            if ((state_q == IDLE) && (state_d == SETUP)) begin
                glitch_seen_q <= 1'b0;
            end else if (glitch_now) begin
                glitch_seen_q <= 1'b1;
            end
            if (glitch_now && (glitch_cnt_q != CntMax)) begin
                glitch_cnt_q <= glitch_cnt_q + ERRW'(1);
            end
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    assign glitch_cnt = '0;
`endif

    // Sample on the edge entering CHECK so the result is ready during the CHECK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s  <= 1'b0;
            qn_s <= 1'b0;
        end else if (state_d == CHECK) begin
            q_s  <= lat_q;
            qn_s <= lat_qn;
        end
    end

    // Written as if/else so an X/Z operand falls through to fail.
    always_comb begin
        pass = 1'b0;
        if (exp_vld) begin
            if ((q_s == exp_q) && (qn_s == !exp_q)) pass = 1'b1;
        end else begin
            if (q_s != qn_s) pass = 1'b1;
        end
`ifdef LATCH_STIM_GLITCH_CHK_EN
        if (glitch_seen_q) pass = 1'b0;
`endif
        done_pass = (state_q == CHECK) && pass;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if ((state_q == CHECK) && !pass && (err_cnt_q != CntMax)) begin
            err_cnt_q <= err_cnt_q + ERRW'(1);
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/latch_stim_gen.sv
// Pin-level driver/checker for a set/reset latch cell.
// Accepts commands on the command bus and plays each as SETUP -> PULSE -> HOLD -> CHECK with
// registered, glitch-free D/CLK/SETB/RSTB drive, then checks Q/QN against an expected model.
// Optional feature: define LATCH_STIM_GLITCH_CHK_EN to count Q/QN changes while the latch is
// opaque (see latch_stim_chk).
// Ports:
//   clk, rst                        : bench clock, async active-high reset
//   cmd                             : command bus (slave side)
//   lat_d, lat_clk                  : cell D and CLK (transparent when high)
//   lat_setb, lat_rstb              : cell async set / reset, active-low
//   lat_q, lat_qn                   : cell outputs
//   done_vld, done_pass             : end-of-command pulse and its check result
//   err_cnt, glitch_cnt             : saturating failure / glitch counts
module latch_stim_gen
    import latch_stim_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PW_CYC    = 2,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned ERRW      = 16
) (
    input  logic            clk,
    input  logic            rst,
    latch_stim_gen_if.slave cmd,
    output logic            lat_d,
    output logic            lat_clk,
    output logic            lat_setb,
    output logic            lat_rstb,
    input  logic            lat_q,
    input  logic            lat_qn,
    output logic            done_vld,
    output logic            done_pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [ERRW-1:0] glitch_cnt
);

    localparam int unsigned CW = phase_cnt_w(SETUP_CYC, PW_CYC, HOLD_CYC);
    localparam logic [CW-1:0] SetupLd = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PulseLd = CW'(PW_CYC - 1);
    localparam logic [CW-1:0] HoldLd  = CW'(HOLD_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_e           op_q, op_d;
    logic          data_q, data_d;
    logic          accept;
    logic          exp_q, exp_vld_q;
    logic          d_nxt, clk_nxt, setb_nxt, rstb_nxt;

    assign accept        = (state_q == IDLE) && cmd.cmd_valid;
    assign cmd.cmd_ready = (state_q == IDLE);

    // Pin drive for the accepted command must be ready on the accept edge itself.
    assign op_d   = accept ? cmd.cmd_op   : op_q;
    assign data_d = accept ? cmd.cmd_data : data_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the phase counter is reloaded on entry to each timed phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_d = SETUP;
                    cnt_d   = SetupLd;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PulseLd;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HoldLd;
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = CHECK;
            end
            CHECK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pin values are decoded from the next state and registered below.
    always_comb begin
        d_nxt    = 1'b0;
        clk_nxt  = 1'b0;
        setb_nxt = 1'b1;
        rstb_nxt = 1'b1;
        done_vld = (state_q == CHECK);
        unique case (state_d)
            SETUP, HOLD: begin
                if (op_d == OP_WRITE) d_nxt = data_d;
            end
            PULSE: begin
                unique case (op_d)
                    OP_WRITE: begin
                        d_nxt   = data_d;
                        clk_nxt = 1'b1;
                    end
                    OP_SET:   setb_nxt = 1'b0;
                    OP_RESET: rstb_nxt = 1'b0;
                    OP_HOLD:  ;
                endcase
            end
            default: ;
        endcase
    end

    // Command register, pin registers and expected-state model
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_HOLD;
            data_q    <= 1'b0;
            lat_d     <= 1'b0;
            lat_clk   <= 1'b0;
            lat_setb  <= 1'b1;
            lat_rstb  <= 1'b1;
            exp_q     <= 1'b0;
            exp_vld_q <= 1'b0;
        end else begin
            op_q     <= op_d;
            data_q   <= data_d;
            lat_d    <= d_nxt;
            lat_clk  <= clk_nxt;
            lat_setb <= setb_nxt;
            lat_rstb <= rstb_nxt;
            if ((state_q == SETUP) && (state_d == PULSE)) begin
                unique case (op_q)
                    OP_WRITE: begin
                        exp_q     <= data_q;
                        exp_vld_q <= 1'b1;
                    end
                    OP_SET: begin
                        exp_q     <= 1'b1;
                        exp_vld_q <= 1'b1;
                    end
                    OP_RESET: begin
                        exp_q     <= 1'b0;
                        exp_vld_q <= 1'b1;
                    end
                    OP_HOLD: ;
                endcase
            end
        end
    end

    latch_stim_chk #(
        .ERRW (ERRW)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .state_q    (state_q),
        .state_d    (state_d),
        .exp_q      (exp_q),
        .exp_vld    (exp_vld_q),
        .lat_q      (lat_q),
        .lat_qn     (lat_qn),
        .done_pass  (done_pass),
        .err_cnt    (err_cnt),
        .glitch_cnt (glitch_cnt)
    );

endmodule

// File: tb/tb_latch_stim_gen.sv
// Directed bench for latch_stim_gen with a behavioural S/R latch cell model.
// ERRW is reduced to 4 so counter saturation is reachable in a short run.
module tb_latch_stim_gen;
    import latch_stim_pkg::*;

    localparam int unsigned ERRW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    latch_stim_gen_if cmd_if ();

    logic            lat_d, lat_clk, lat_setb, lat_rstb;
    logic            lat_q, lat_qn;
    logic            done_vld, done_pass;
    logic [ERRW-1:0] err_cnt, glitch_cnt;

    int total = 0;
    int bad   = 0;

    // Cell model and fault knobs
    logic cell_q   = 1'b0;
    logic stuck0   = 1'b0;
    logic flip     = 1'b0;
    logic force_eq = 1'b0;
    logic q_base;

    always #5 clk = ~clk;

    always @(lat_d or lat_clk or lat_setb or lat_rstb) begin
        if (!lat_rstb)      cell_q = 1'b0;
        else if (!lat_setb) cell_q = 1'b1;
        else if (lat_clk)   cell_q = lat_d;
    end

    assign q_base = stuck0 ? 1'b0 : cell_q;
    assign lat_q  = force_eq ? 1'b1 : (q_base ^ flip);
    assign lat_qn = force_eq ? 1'b1 : ~q_base;

    latch_stim_gen #(
        .SETUP_CYC (2),
        .PW_CYC    (2),
        .HOLD_CYC  (2),
        .ERRW      (ERRW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .lat_d      (lat_d),
        .lat_clk    (lat_clk),
        .lat_setb   (lat_setb),
        .lat_rstb   (lat_rstb),
        .lat_q      (lat_q),
        .lat_qn     (lat_qn),
        .done_vld   (done_vld),
        .done_pass  (done_pass),
        .err_cnt    (err_cnt),
        .glitch_cnt (glitch_cnt)
    );

    // Per-cycle trace of one command; index = cycle after accept (0 = accept cycle).
    logic d_tr[9], clk_tr[9], setb_tr[9], rstb_tr[9], done_tr[9], pass_tr[9], rdy_tr[9];

    task automatic record(input int k);
        d_tr[k]    = lat_d;
        clk_tr[k]  = lat_clk;
        setb_tr[k] = lat_setb;
        rstb_tr[k] = lat_rstb;
        done_tr[k] = done_vld;
        pass_tr[k] = done_pass;
        rdy_tr[k]  = cmd_if.cmd_ready;
    endtask

    // Called 1ns after a rising edge in IDLE; returns 1ns after the edge ending cycle 7.
    task automatic run_cmd(input op_e op, input logic data, input int glitch_at);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        record(0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) cmd_if.cmd_valid = 1'b0;
            if (k == glitch_at) flip = 1'b1;
            if (k == glitch_at + 1) flip = 1'b0;
            record(k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (lat_d !== 1'b0) begin bad++; $display("FAIL rst_lat_d got %b want 0", lat_d); end
        total++; if (lat_clk !== 1'b0) begin bad++; $display("FAIL rst_lat_clk got %b want 0", lat_clk); end
        total++; if (lat_setb !== 1'b1) begin bad++; $display("FAIL rst_setb got %b want 1", lat_setb); end
        total++; if (lat_rstb !== 1'b1) begin bad++; $display("FAIL rst_rstb got %b want 1", lat_rstb); end
        total++; if (done_vld !== 1'b0) begin bad++; $display("FAIL rst_done_vld got %b want 0", done_vld); end
        total++; if (done_pass !== 1'b0) begin bad++; $display("FAIL rst_done_pass got %b want 0", done_pass); end
        total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
        total++; if (glitch_cnt !== 4'd0) begin bad++; $display("FAIL rst_glitch_cnt got %0d want 0", glitch_cnt); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_hold_unwritten();
        run_cmd(OP_HOLD, 1'b0, 0);
        for (int k = 0; k < 9; k++) begin
            total++;
            if ({d_tr[k], clk_tr[k], setb_tr[k], rstb_tr[k]} !== 4'b0011) begin
                bad++;
                $display("FAIL hold_pins cycle %0d got %b%b%b%b want 0011", k, d_tr[k], clk_tr[k], setb_tr[k], rstb_tr[k]);
            end
            total++;
            if (done_tr[k] !== (k == 7)) begin
                bad++; $display("FAIL hold_done cycle %0d got %b want %b", k, done_tr[k], k == 7);
            end
        end
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL hold_pass got %b want 1", pass_tr[7]); end
        total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL hold_err got %0d want 0", err_cnt); end
        // Unknown model state but q == qn: illegal cell output
        force_eq = 1'b1;
        run_cmd(OP_HOLD, 1'b0, 0);
        force_eq = 1'b0;
        total++; if (pass_tr[7] !== 1'b0) begin bad++; $display("FAIL hold_qeq_pass got %b want 0", pass_tr[7]); end
        total++; if (err_cnt !== 4'd1) begin bad++; $display("FAIL hold_qeq_err got %0d want 1", err_cnt); end
    endtask

    task automatic test_write();
        run_cmd(OP_WRITE, 1'b1, 0);
        for (int k = 0; k < 9; k++) begin
            total++;
            if (d_tr[k] !== (k >= 1 && k <= 6)) begin
                bad++; $display("FAIL wr1_d cycle %0d got %b want %b", k, d_tr[k], k >= 1 && k <= 6);
            end
            total++;
            if (clk_tr[k] !== (k == 3 || k == 4)) begin
                bad++; $display("FAIL wr1_clk cycle %0d got %b want %b", k, clk_tr[k], k == 3 || k == 4);
            end
            total++;
            if (rdy_tr[k] !== (k == 0 || k == 8)) begin
                bad++; $display("FAIL wr1_ready cycle %0d got %b want %b", k, rdy_tr[k], k == 0 || k == 8);
            end
            total++;
            if (done_tr[k] !== (k == 7)) begin
                bad++; $display("FAIL wr1_done cycle %0d got %b want %b", k, done_tr[k], k == 7);
            end
        end
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL wr1_pass got %b want 1", pass_tr[7]); end
        run_cmd(OP_WRITE, 1'b0, 0);
        total++; if (d_tr[4] !== 1'b0) begin bad++; $display("FAIL wr0_d got %b want 0", d_tr[4]); end
        total++; if (clk_tr[3] !== 1'b1) begin bad++; $display("FAIL wr0_clk got %b want 1", clk_tr[3]); end
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL wr0_pass got %b want 1", pass_tr[7]); end
        total++; if (err_cnt !== 4'd1) begin bad++; $display("FAIL wr_err got %0d want 1", err_cnt); end
    endtask

    task automatic test_back_to_back();
        logic setb_a[9], rstb_a[9];
        logic pass_a;
        run_cmd(OP_SET, 1'b0, 0);
        for (int k = 0; k < 9; k++) begin
            setb_a[k] = setb_tr[k];
            rstb_a[k] = rstb_tr[k];
        end
        pass_a = pass_tr[7];
        run_cmd(OP_RESET, 1'b1, 0);
        for (int k = 0; k < 9; k++) begin
            total++;
            if ({setb_a[k], rstb_a[k]} !== {!(k == 3 || k == 4), 1'b1}) begin
                bad++; $display("FAIL b2b_set_pins cycle %0d got %b%b", k, setb_a[k], rstb_a[k]);
            end
            total++;
            if ({setb_tr[k], rstb_tr[k]} !== {1'b1, !(k == 3 || k == 4)}) begin
                bad++; $display("FAIL b2b_rst_pins cycle %0d got %b%b", k, setb_tr[k], rstb_tr[k]);
            end
        end
        total++; if (d_tr[2] !== 1'b0) begin bad++; $display("FAIL b2b_rst_d got %b want 0", d_tr[2]); end
        total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL b2b_set_pass got %b want 1", pass_a); end
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL b2b_rst_pass got %b want 1", pass_tr[7]); end
        run_cmd(OP_HOLD, 1'b0, 0);
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL retain_pass got %b want 1", pass_tr[7]); end
        total++; if (err_cnt !== 4'd1) begin bad++; $display("FAIL b2b_err got %0d want 1", err_cnt); end
    endtask

    task automatic test_stuck();
        stuck0 = 1'b1;
        run_cmd(OP_WRITE, 1'b1, 0);
        total++; if (pass_tr[7] !== 1'b0) begin bad++; $display("FAIL stuck_pass got %b want 0", pass_tr[7]); end
        total++; if (err_cnt !== 4'd2) begin bad++; $display("FAIL stuck_err got %0d want 2", err_cnt); end
        for (int i = 0; i < 16; i++) run_cmd(OP_WRITE, 1'b1, 0);
        stuck0 = 1'b0;
        total++; if (err_cnt !== 4'hF) begin bad++; $display("FAIL stuck_sat got %0d want 15", err_cnt); end
    endtask

    task automatic test_glitch();
        run_cmd(OP_WRITE, 1'b1, 5);
`ifdef LATCH_STIM_GLITCH_CHK_EN
        total++; if (glitch_cnt !== 4'd1) begin bad++; $display("FAIL glitch_cnt got %0d want 1", glitch_cnt); end
        total++; if (pass_tr[7] !== 1'b0) begin bad++; $display("FAIL glitch_pass got %b want 0", pass_tr[7]); end
`else
        total++; if (glitch_cnt !== 4'd0) begin bad++; $display("FAIL glitch_cnt got %0d want 0", glitch_cnt); end
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL glitch_pass got %b want 1", pass_tr[7]); end
`endif
        total++; if (err_cnt !== 4'hF) begin bad++; $display("FAIL glitch_err got %0d want 15", err_cnt); end
    endtask

    task automatic test_reset_mid_pulse();
        logic seen_done;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_WRITE;
        cmd_if.cmd_data  = 1'b1;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (lat_clk !== 1'b1) begin bad++; $display("FAIL mid_pulse_clk got %b want 1", lat_clk); end
        rst = 1'b1;
        #1;
        total++; if (lat_clk !== 1'b0) begin bad++; $display("FAIL mid_rst_clk got %b want 0", lat_clk); end
        total++; if (lat_d !== 1'b0) begin bad++; $display("FAIL mid_rst_d got %b want 0", lat_d); end
        total++; if ({lat_setb, lat_rstb} !== 2'b11) begin bad++; $display("FAIL mid_rst_sr got %b want 11", {lat_setb, lat_rstb}); end
        total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL mid_rst_err got %0d want 0", err_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done_vld !== 1'b0) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL mid_rst_no_done got %b want 0", seen_done); end
        total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got %b want 1", cmd_if.cmd_ready); end
        // Model must be unknown again: only q != qn is required, so a stale exp_q=1 would fail here.
        stuck0 = 1'b1;
        run_cmd(OP_HOLD, 1'b0, 0);
        stuck0 = 1'b0;
        total++; if (pass_tr[7] !== 1'b1) begin bad++; $display("FAIL mid_rst_model got %b want 1", pass_tr[7]); end
        total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL mid_rst_err_after got %0d want 0", err_cnt); end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_HOLD;
        cmd_if.cmd_data  = 1'b0;
        test_reset();
        test_hold_unwritten();
        test_write();
        test_back_to_back();
        test_stuck();
        test_glitch();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
